// File: rtl/program_ram.sv
// program_ram: single-port synchronous CPU RAM (2^ADDR_W x DATA_W) with an
// optional byte-stream program loader that fills memory from address 0 while
// holding the CPU off.
// Build option: define PROGRAM_RAM_LOADER_EN to compile the loader; without it
// the load_* inputs are ignored and load_ready/load_done/cpu_hold read 0.
// The loader assembles two bytes per word, high byte first (DATA_W = 16).
module program_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  input  logic              ram_rw,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              load_valid,
  input  logic [7:0]        load_byte,
  output logic              load_ready,
  output logic              load_done,
  output logic              cpu_hold
);

  localparam int DEPTH = 1 << ADDR_W;

  // Storage is deliberately not reset so it can map onto block RAM and keep
  // a loaded program across a CPU reset.
  logic [DATA_W-1:0] mem [DEPTH];

  // Loader-side write request (only ever active while the CPU is held).
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;

  // Single shared write port.
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // Write-port mux: loader and CPU are mutually exclusive through cpu_hold.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = address;
    mem_wdata = wr_data;
    if (ld_we) begin
      mem_we    = 1'b1;
      mem_waddr = ld_addr;
      mem_wdata = ld_data;
    end else if (!cpu_hold && ram_rw) begin
      mem_we = 1'b1;
    end
  end

  // Memory array write.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Registered CPU read data, write-first; frozen while the CPU is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (!cpu_hold) begin
      rd_data <= ram_rw ? wr_data : mem[address];
    end
  end

`ifdef PROGRAM_RAM_LOADER_EN

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HI,
    ST_LO,
    ST_DONE
  } load_state_t;

  load_state_t     state_reg, state_next;
  // ptr/len are one bit wider than the address so a full-depth load (len =
  // DEPTH) is representable and the final word ends the load without wrapping.
  logic [ADDR_W:0] ptr_reg, ptr_next;
  logic [ADDR_W:0] len_reg, len_next;
  logic [7:0]      hi_reg, hi_next;

  // Loader state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      ptr_reg   <= '0;
      len_reg   <= '0;
      hi_reg    <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      len_reg   <= len_next;
      hi_reg    <= hi_next;
    end
  end

  // Loader next-state, handshake and memory-write decode.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    len_next   = len_reg;
    hi_next    = hi_reg;
    ld_we      = 1'b0;
    ld_addr    = ptr_reg[ADDR_W-1:0];
    ld_data    = DATA_W'({hi_reg, load_byte});
    load_ready = 1'b0;
    load_done  = 1'b0;
    cpu_hold   = 1'b1;
    case (state_reg)
      ST_IDLE: begin
        cpu_hold = 1'b0;
        if (load_start) begin
          len_next   = load_len;
          ptr_next   = '0;
          state_next = (load_len == '0) ? ST_DONE : ST_HI;
        end
      end
      ST_HI: begin
        load_ready = 1'b1;
        if (load_valid) begin
          hi_next    = load_byte;
          state_next = ST_LO;
        end
      end
      ST_LO: begin
        load_ready = 1'b1;
        if (load_valid) begin
          ld_we = 1'b1;
          if (ptr_reg == len_reg - 1'b1) begin
            state_next = ST_DONE;
          end else begin
            ptr_next   = ptr_reg + 1'b1;
            state_next = ST_HI;
          end
        end
      end
      ST_DONE: begin
        load_done  = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

`else

  // Plain CPU RAM: no loader, CPU never held.
  assign ld_we      = 1'b0;
  assign ld_addr    = '0;
  assign ld_data    = '0;
  assign load_ready = 1'b0;
  assign load_done  = 1'b0;
  assign cpu_hold   = 1'b0;

  logic unused_load_inputs;
  assign unused_load_inputs = ^{load_start, load_len, load_valid, load_byte};

`endif

endmodule
